// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty bank and the controller that feeds it.
package pwm_pkg;

  localparam int PWM_DW = 8;
  localparam logic [7:0] PWM_CNT_MAX = 8'd254;
  localparam int PWM_NCH_DEFAULT = 4;

  typedef logic [PWM_DW-1:0] pwm_duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, pending flag and registered compare output.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [PWM_DW-1:0] duty_in_i,
  input  logic              boundary_i,
  input  logic [PWM_DW-1:0] cnt_i,
  output logic              pwm_o,
  output logic              pending_o,
  output logic [PWM_DW-1:0] active_o
);

  pwm_duty_t shadow_q, shadow_d;
  pwm_duty_t active_q, active_d;
  logic      pending_q, pending_d;
  logic      pwm_q, pwm_d;

  // Next state: writes go to the shadow; the active value only moves at a period boundary.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    pwm_d     = 1'b0;

    if (wr_en_i) begin
      shadow_d = duty_in_i;
    end else begin
      shadow_d = shadow_q;
    end

    if (boundary_i) begin
      // A write landing on the boundary itself goes straight into the new period.
      pending_d = 1'b0;
      if (wr_en_i) begin
        active_d = duty_in_i;
      end else begin
        active_d = shadow_q;
      end
    end else begin
      active_d = active_q;
      if (wr_en_i) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
    end

    // cnt tops out at 254, so a duty of 255 keeps the output high all period.
    pwm_d = (cnt_i < active_q);
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= 8'd0;
      active_q  <= 8'd0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign pending_o = pending_q;
  assign active_o  = active_q;

endmodule

// File: rtl/pwm_duty_bank.sv
// PWM duty bank: prescaler, period counter, write decode, period_start and active-duty readback.
module pwm_duty_bank
  import pwm_pkg::*;
#(
  parameter int NCH      = PWM_NCH_DEFAULT,
  parameter int PRESCALE = 1,
  localparam int CSW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [CSW-1:0]    ch_sel_i,
  input  logic [PWM_DW-1:0] duty_in_i,
  input  logic [CSW-1:0]    rd_ch_i,
  output logic [NCH-1:0]    pwm_out_o,
  output logic              period_start_o,
  output logic [NCH-1:0]    upd_pending_o,
  output logic [PWM_DW-1:0] rd_duty_o
);

  logic [PSW-1:0] presc_cnt_q, presc_cnt_d;
  pwm_duty_t      cnt_q, cnt_d;
  logic           period_start_q, period_start_d;
  pwm_duty_t      rd_duty_q, rd_duty_d;
  logic           tick;
  logic           boundary;
  logic [NCH-1:0] wr_en;
  logic [NCH-1:0] pwm_s;
  logic [NCH-1:0] pending_s;
  pwm_duty_t      active_s [NCH];

  // Prescaler, period counter and period-start detection.
  always_comb begin
    tick     = (presc_cnt_q == PSW'(PRESCALE - 1));
    boundary = tick && (cnt_q == PWM_CNT_MAX);

    if (tick) begin
      presc_cnt_d = PSW'(0);
    end else begin
      presc_cnt_d = presc_cnt_q + PSW'(1);
    end

    if (boundary) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // Registered so it lines up with the first pwm_out cycle of the period.
    period_start_d = (cnt_q == 8'd0) && (presc_cnt_q == PSW'(0));
  end

  // Write-strobe decode and readback mux of the active duties.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_en[i] = we_i && (ch_sel_i == CSW'(i));
    end
    if (int'(rd_ch_i) < NCH) begin
      rd_duty_d = active_s[rd_ch_i];
    end else begin
      rd_duty_d = 8'd0;
    end
  end

  // Top-level state registers; reset restarts the period from cnt=0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt_q    <= PSW'(0);
      cnt_q          <= 8'd0;
      period_start_q <= 1'b0;
      rd_duty_q      <= 8'd0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      rd_duty_q      <= rd_duty_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en[g]),
      .duty_in_i  (duty_in_i),
      .boundary_i (boundary),
      .cnt_i      (cnt_q),
      .pwm_o      (pwm_s[g]),
      .pending_o  (pending_s[g]),
      .active_o   (active_s[g])
    );
  end

  assign pwm_out_o      = pwm_s;
  assign upd_pending_o  = pending_s;
  assign period_start_o = period_start_q;
  assign rd_duty_o      = rd_duty_q;

endmodule

// File: tb/tb_pwm_duty_bank.sv
// Directed scoreboard bench for pwm_duty_bank at PRESCALE=1 (dut) and PRESCALE=4 (dut4).
module tb_pwm_duty_bank;

  logic       clk = 1'b0;
  logic       rst, we, rst4, we4;
  logic [1:0] ch_sel, rd_ch, ch_sel4, rd_ch4;
  logic [7:0] duty_in, duty4;
  logic [3:0] pwm_out, upd_pending, pwm_out4, upd_pending4;
  logic       period_start, period_start4;
  logic [7:0] rd_duty, rd_duty4;

  always #5 clk = ~clk;

  pwm_duty_bank #(.NCH(4), .PRESCALE(1)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .ch_sel_i(ch_sel), .duty_in_i(duty_in),
    .rd_ch_i(rd_ch), .pwm_out_o(pwm_out), .period_start_o(period_start),
    .upd_pending_o(upd_pending), .rd_duty_o(rd_duty)
  );

  pwm_duty_bank #(.NCH(4), .PRESCALE(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .we_i(we4), .ch_sel_i(ch_sel4), .duty_in_i(duty4),
    .rd_ch_i(rd_ch4), .pwm_out_o(pwm_out4), .period_start_o(period_start4),
    .upd_pending_o(upd_pending4), .rd_duty_o(rd_duty4)
  );

  typedef struct { string tag; logic [31:0] val; } sb_item_t;
  typedef struct { int at; int ch; int val; } wr_item_t;

  sb_item_t   sb_q[$];
  wr_item_t   wr_q[$];
  int         total = 0;
  int         bad = 0;
  int         hi_cnt[4];
  logic [3:0] first_v;
  logic [3:0] pend_hist[255];
  logic [7:0] rd_hist[255];
  int         ps_in_period;
  int         steps;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow: observed %0d required a queued expectation", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.val) else begin
        bad++;
        $error("FAIL %s: observed %0d required %0d", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic add_wr(input int at, input int ch, input int val);
    wr_item_t w;
    w.at = at; w.ch = ch; w.val = val;
    wr_q.push_back(w);
  endtask

  // Observe one 255-clock period of dut starting at the current (period_start) sample,
  // driving any scheduled writes at their sample index.
  task automatic measure();
    wr_item_t w;
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    ps_in_period = 0;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) step();
      for (int c = 0; c < 4; c++) if (pwm_out[c] === 1'b1) hi_cnt[c]++;
      if (i == 0) first_v = pwm_out;
      pend_hist[i] = upd_pending;
      rd_hist[i]   = rd_duty;
      if (period_start === 1'b1) ps_in_period++;
      if (wr_q.size() > 0 && wr_q[0].at == i) begin
        w = wr_q.pop_front();
        we = 1'b1; ch_sel = 2'(w.ch); duty_in = 8'(w.val);
      end else begin
        we = 1'b0;
      end
    end
    we = 1'b0;
  endtask

  task automatic next_period(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 3000);
  endtask

  initial begin
    int h;
    // Reset with a write pending on the inputs: it must be ignored.
    rst = 1'b1; we = 1'b1; ch_sel = 2'd1; duty_in = 8'hFF; rd_ch = 2'd1;
    rst4 = 1'b1; we4 = 1'b0; ch_sel4 = 2'd0; duty4 = 8'd0; rd_ch4 = 2'd1;
    step(); step();
    expect_val("rst_pwm", 32'd0);   check(32'(pwm_out));
    expect_val("rst_pend", 32'd0);  check(32'(upd_pending));
    expect_val("rst_rd", 32'd0);    check(32'(rd_duty));
    expect_val("rst_ps", 32'd0);    check(32'(period_start));

    // Release; dut4 gets ch1=32 on the very first active edge.
    rst = 1'b0; we = 1'b0; rst4 = 1'b0;
    we4 = 1'b1; ch_sel4 = 2'd1; duty4 = 8'd32;
    step();
    we4 = 1'b0;
    expect_val("rel_ps", 32'd1);    check(32'(period_start));
    expect_val("p4_pend", 32'd2);   check(32'(upd_pending4));

    // P0: everything idle at duty 0.
    measure();
    expect_val("p0_hi_sum", 32'd0);
    check(32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]));
    expect_val("p0_ps_count", 32'd1); check(32'(ps_in_period));

    // P1: mid-period write ch1=64 at cnt=100.
    next_period(steps);
    expect_val("p1_gap", 32'd1);    check(32'(steps));
    add_wr(99, 1, 64);
    measure();
    expect_val("p1_hi1", 32'd0);      check(32'(hi_cnt[1]));
    expect_val("p1_pend_pre", 32'd0); check(32'(pend_hist[99][1]));
    expect_val("p1_pend_set", 32'd1); check(32'(pend_hist[100][1]));
    expect_val("p1_pend_b", 32'd1);   check(32'(pend_hist[253][1]));
    expect_val("p1_pend_clr", 32'd0); check(32'(pend_hist[254][1]));
    expect_val("p1_rd_old", 32'd0);   check(32'(rd_hist[254]));

    // P2: ch1 now 64; schedule the extremes.
    next_period(steps);
    expect_val("p2_gap", 32'd1);    check(32'(steps));
    expect_val("p2_rd", 32'd64);    check(32'(rd_duty));
    add_wr(10, 0, 0); add_wr(11, 2, 255); add_wr(12, 3, 1);
    measure();
    expect_val("p2_hi1", 32'd64);   check(32'(hi_cnt[1]));
    expect_val("p2_first1", 32'd1); check(32'(first_v[1]));

    // P3..P5: extremes over three back-to-back periods; overwrite and B-cycle write in P5.
    for (int k = 0; k < 3; k++) begin
      next_period(steps);
      expect_val("ext_gap", 32'd1);  check(32'(steps));
      if (k == 2) begin
        add_wr(20, 2, 10); add_wr(150, 2, 200); add_wr(253, 0, 128);
      end
      measure();
      expect_val("ext_hi0", 32'd0);    check(32'(hi_cnt[0]));
      expect_val("ext_hi2", 32'd255);  check(32'(hi_cnt[2]));
      expect_val("ext_hi3", 32'd1);    check(32'(hi_cnt[3]));
      expect_val("ext_first3", 32'd1); check(32'(first_v[3]));
      if (k == 2) begin
        expect_val("ow_pend2", 32'd1);   check(32'(pend_hist[200][2]));
        expect_val("bw_pend_b", 32'd0);  check(32'(pend_hist[254] & 4'b0101));
      end
    end

    // P6: overwrite wins, B-cycle write applies immediately.
    next_period(steps);
    expect_val("p6_gap", 32'd1);    check(32'(steps));
    add_wr(50, 0, 200);
    measure();
    expect_val("p6_hi0", 32'd128);  check(32'(hi_cnt[0]));
    expect_val("p6_hi2", 32'd200);  check(32'(hi_cnt[2]));
    expect_val("p6_hi3", 32'd1);    check(32'(hi_cnt[3]));
    expect_val("p6_pend_end", 32'd0); check(32'(pend_hist[254][0]));

    // P7: ch0=200 active, reset pulse at cnt=50.
    next_period(steps);
    expect_val("p7_gap", 32'd1);    check(32'(steps));
    rd_ch = 2'd0;
    repeat (49) step();
    expect_val("pre_rst_pwm0", 32'd1); check(32'(pwm_out[0]));
    expect_val("pre_rst_rd", 32'd200); check(32'(rd_duty));
    rst = 1'b1;
    step();
    expect_val("mid_rst_pwm", 32'd0);  check(32'(pwm_out));
    rst = 1'b0;
    step();
    expect_val("post_rst_ps", 32'd1);  check(32'(period_start));
    measure();
    expect_val("post_hi0", 32'd0);     check(32'(hi_cnt[0]));
    expect_val("post_hi2", 32'd0);     check(32'(hi_cnt[2]));
    expect_val("post_rd", 32'd0);      check(32'(rd_hist[254]));

    // PRESCALE=4: period spacing and high time of ch1=32.
    steps = 0;
    do begin step(); steps++; end while (period_start4 !== 1'b1 && steps < 2000);
    steps = 0; h = 0;
    do begin
      if (pwm_out4[1] === 1'b1) h++;
      step();
      steps++;
    end while (period_start4 !== 1'b1 && steps < 3000);
    expect_val("p4_spacing", 32'd1020); check(32'(steps));
    expect_val("p4_hi1", 32'd128);      check(32'(h));
    expect_val("p4_rd", 32'd32);        check(32'(rd_duty4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_bank.md
# pwm_duty_bank

Receiving end of the controller's duty-write interface (`we`/`ch_sel`/`duty_in`). Holds one shadow and one active 8-bit duty value per channel and generates the PWM outputs. Writes land in shadow registers. Shadows transfer to the active registers only at a PWM period boundary, so an output never sees a mid-period duty change. Sits between the controller and the output pins; also provides a registered readback of active duties.

## Interface
- `NCH`, 4: number of channels. `ch_sel` width is `$clog2(NCH)`, 2 at default.
- `PRESCALE`, 1: clocks per PWM count tick; legal range ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `we`  in  1  write strobe from controller; one write per cycle.
- `ch_sel`  in  2  target channel of write.
- `duty_in`  in  8  duty value, in counts of 255.
- `rd_ch`  in  2  readback channel select.
- `pwm_out`  out  NCH  PWM outputs, registered.
- `period_start`  out  1  one-clock pulse, first clock of each PWM period.
- `upd_pending`  out  NCH  bit i set while shadow[i] holds a write not yet applied.
- `rd_duty`  out  8  registered `active[rd_ch]`.

## Operation
- Reset: `shadow[*]`, `active[*]`, `presc_cnt`, `cnt` and all outputs go to 0.
  - `we` in a reset cycle is ignored.
  - Reset asserted mid-period aborts the period. Counting restarts from `cnt=0` on the first non-reset cycle.
- Prescaler: `presc_cnt` counts 0..PRESCALE-1 and wraps. `tick` = (`presc_cnt == PRESCALE-1`). At `PRESCALE=1`, `tick` is always 1.
- Period counter: `cnt` 0..254, increments on `tick`. Boundary `B` = `tick && cnt==254`. At `B`, `cnt` goes to 0. Period is 255 ticks.
- Write, when `we=1`: `shadow[ch_sel] <= duty_in` and `upd_pending[ch_sel] <= 1`.
  - Repeated writes within a period: last value wins.
- Update at `B`: every `active[i] <= shadow[i]` and `upd_pending <= 0`.
  - If `we` coincides with `B`, the written channel's active register takes `duty_in` directly. That value applies to the starting period and `upd_pending` for that channel ends 0.
- Output: `pwm_out[i] <= (cnt < active[i])`, 8-bit unsigned compare.
  - Duty 0 gives constant low.
  - Duty 255 gives constant high, since `cnt` never exceeds 254.
  - Duty D gives exactly D·PRESCALE high clocks per 255·PRESCALE-clock period, with no glitch at the boundary.
- `period_start <= (cnt==0 && presc_cnt==0)`, registered. It aligns with the first `pwm_out` cycle of the period.
- `rd_duty <= active[rd_ch]`, one-clock latency. It shows the active value, not the shadow.

## Timing
- Write at edge t: `shadow` and `upd_pending` visible after t.
- Effect on `pwm_out`: from the clock after the next `B`. Worst case latency is 255·PRESCALE+1 clocks.
- `pwm_out` lags `cnt` by one clock. `period_start` lags by one clock identically.
- `rd_ch` to `rd_duty`: 1 clock. An active update at `B` is visible on `rd_duty` 1 clock after `B`.
- No backpressure: `we` is always accepted. There is no busy or ready signal.

## Structure
- Shared package `pwm_pkg` holds:
  - `PWM_DW=8`
  - `PWM_CNT_MAX=8'd254`
  - `pwm_duty_t` (`logic [7:0]`)
  - default `NCH`
- The controller imports the same package for its `duty_in` type.
- Sub-module `pwm_channel`, instantiated NCH times, containing:
  - shadow and active registers
  - pending flag
  - comparator and output flop
  - inputs: `wr_en`, `duty_in`, `boundary`, `cnt`
- The top level holds the prescaler, period counter, `period_start`, write decode and readback mux.

## Test plan
- Reset values:
  - Stimulus: assert `rst` 2 clocks with `we=1`, `ch_sel=1`, `duty_in=8'hFF`.
  - Required: `pwm_out=0`, `upd_pending=0`, `rd_duty=0`, `period_start` low.
  - After release: first `period_start` 1 clock later; all outputs stay low (duty 0).
- Mid-period write:
  - Stimulus: at `PRESCALE=1`, write ch1=64 at `cnt=100`.
  - Required: `upd_pending[1]=1`; `pwm_out[1]` stays 0 until the next `period_start`.
  - Then `pwm_out[1]` is high exactly 64 clocks per 255; `upd_pending[1]` clears at `B`; `rd_duty(rd_ch=1)` reads 64.
- Extremes:
  - Stimulus: ch0=0, ch2=255, ch3=1.
  - Required: `pwm_out[0]` never high; `pwm_out[2]` never low across 3 periods including boundaries; `pwm_out[3]` high only in the `period_start` cycle.
- Boundary collision and overwrite:
  - Stimulus: write ch2=10 then ch2=200 within one period.
  - Required: the next period shows 200 high clocks.
  - Stimulus: write ch0=128 in the `B` cycle.
  - Required: 128 high clocks in the immediately starting period; `upd_pending[0]=0`.
- Prescaler:
  - Stimulus: `PRESCALE=4`, ch1=32.
  - Required: `period_start` spacing 1020 clocks; `pwm_out[1]` high 128 clocks per period.
- Reset mid-operation:
  - Stimulus: ch0=200 active, pulse `rst` at `cnt=50`.
  - Required: `pwm_out` goes 0 the next clock; `active` resets to 0.
  - After release: first `period_start` 1 clock after release; ch0 stays low until rewritten.
